// File: rtl/jtdd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtdd_pkg: shared palette constants, selection type and layer-priority mux. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package jtdd_pkg;

  localparam logic [1:0] CHAR_BASE  = 2'b00;
  localparam logic [1:0] OBJ_BASE   = 2'b01;
  localparam int         PAL_AW     = 9;
  localparam int         COLMIX_LAT = 3;

  typedef struct packed {
    logic              black;
    logic [PAL_AW-1:0] idx;
  } pal_sel_t;

  // en = {scr, obj, char}; a disabled scroll layer lands on entry 0x100 and is blacked out.
  function automatic pal_sel_t pick_layer(
    input logic [6:0] char_pxl,
    input logic [6:0] obj_pxl,
    input logic [7:0] scr_pxl,
    input logic [2:0] en
  );
    pal_sel_t sel;
    sel.black = 1'b0;
    if (en[0] && char_pxl[3:0] != 4'd0) begin
      sel.idx = {CHAR_BASE, char_pxl};
    end else if (en[1] && obj_pxl[3:0] != 4'd0) begin
      sel.idx = {OBJ_BASE, obj_pxl};
    end else if (!en[2]) begin
      sel.idx   = 9'h100;
      sel.black = 1'b1;
    end else begin
      sel.idx = {1'b1, scr_pxl};
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_dual_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtframe_dual_ram: single-clock RAM, port A read/write, port B gated read.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module jtframe_dual_ram #(
  parameter int    DW      = 8,
  parameter int    AW      = 9,
  parameter string SIMFILE = ""
) (
  input  logic          clk,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] data0_i,
  input  logic          we0_i,
  output logic [DW-1:0] q0_o,
  input  logic          cen1_i,
  input  logic [AW-1:0] addr1_i,
  output logic [DW-1:0] q1_o
);

  logic [DW-1:0] mem_q [0:(2**AW)-1];
  logic [DW-1:0] q0_q;
  logic [DW-1:0] q1_q;

  // Port A is read-before-write: a same-cycle write returns the previous word.
  always_ff @(posedge clk) begin
    q0_q <= mem_q[addr0_i];
    if (we0_i) mem_q[addr0_i] <= data0_i;
  end

  always_ff @(posedge clk) begin
    if (cen1_i) q1_q <= mem_q[addr1_i];
  end

  assign q0_o = q0_q;
  assign q1_o = q1_q;

  // Preload images are attached by simulation models; synthesis starts from an unloaded array.
  generate
    if (SIMFILE != "") begin : g_simfile
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/jtdd_colmix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtdd_colmix: char/obj/scroll priority, palette lookup, blank-gated RGB.    |
// | Option macro: JTDD_COLMIX_DEBUG_EN adds gfx_en per-layer enables.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module jtdd_colmix
  import jtdd_pkg::*;
#(
  parameter string SIMFILE_RG = "pal_rg.bin",
  parameter string SIMFILE_B  = "pal_b.bin"
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       cen_E,
  input  logic [9:0] cpu_AB,
  input  logic       pal_cs,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  output logic [7:0] pal_dout,
  input  logic [6:0] char_pxl,
  input  logic [7:0] obj_pxl,
  input  logic [7:0] scr_pxl,
  input  logic       LHBL,
  input  logic       LVBL,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
`ifdef JTDD_COLMIX_DEBUG_EN
  ,
  input  logic [2:0] gfx_en
`endif
);

  logic [2:0] w_layer_en;
  pal_sel_t   w_sel;
  pal_sel_t   sel_q;
  logic       black2_q;
  logic [1:0] blank_q [COLMIX_LAT];
  logic [3:0] red_q, green_q, blue_q;
  logic       bank_q;
  logic       w_cpu_we, w_we_rg, w_we_b;
  logic [7:0] w_rg_cpu, w_b_cpu, w_rg_vid, w_b_vid;
  logic       w_unused;

`ifdef JTDD_COLMIX_DEBUG_EN
  assign w_layer_en = gfx_en;
`else
  assign w_layer_en = 3'b111;
`endif

  always_comb begin
    w_sel = pick_layer(char_pxl, obj_pxl[6:0], scr_pxl, w_layer_en);
  end

  assign w_cpu_we = pal_cs & ~cpu_wrn & cen_E;
  assign w_we_rg  = w_cpu_we & ~cpu_AB[9];
  assign w_we_b   = w_cpu_we &  cpu_AB[9];

  jtframe_dual_ram #(.DW(8), .AW(PAL_AW), .SIMFILE(SIMFILE_RG)) u_pal_rg (
    .clk     (clk),
    .addr0_i (cpu_AB[PAL_AW-1:0]),
    .data0_i (cpu_dout),
    .we0_i   (w_we_rg),
    .q0_o    (w_rg_cpu),
    .cen1_i  (pxl_cen),
    .addr1_i (sel_q.idx),
    .q1_o    (w_rg_vid)
  );

  jtframe_dual_ram #(.DW(8), .AW(PAL_AW), .SIMFILE(SIMFILE_B)) u_pal_b (
    .clk     (clk),
    .addr0_i (cpu_AB[PAL_AW-1:0]),
    .data0_i (cpu_dout),
    .we0_i   (w_we_b),
    .q0_o    (w_b_cpu),
    .cen1_i  (pxl_cen),
    .addr1_i (sel_q.idx),
    .q1_o    (w_b_vid)
  );

  // Bank select is held so the read mux lines up with the registered RAM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_q <= 1'b0;
    else        bank_q <= cpu_AB[9];
  end

  assign pal_dout = bank_q ? w_b_cpu : w_rg_cpu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      black2_q <= 1'b0;
      for (int i = 0; i < COLMIX_LAT; i++) blank_q[i] <= 2'b00;
      red_q    <= 4'd0;
      green_q  <= 4'd0;
      blue_q   <= 4'd0;
    end else if (pxl_cen) begin
      sel_q      <= w_sel;
      black2_q   <= sel_q.black;
      blank_q[0] <= {LHBL, LVBL};
      for (int i = 1; i < COLMIX_LAT; i++) blank_q[i] <= blank_q[i-1];
      if ((&blank_q[COLMIX_LAT-2]) && !black2_q) begin
        red_q   <= w_rg_vid[3:0];
        green_q <= w_rg_vid[7:4];
        blue_q  <= w_b_vid[3:0];
      end else begin
        red_q   <= 4'd0;
        green_q <= 4'd0;
        blue_q  <= 4'd0;
      end
    end
  end

  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign LHBL_dly = blank_q[COLMIX_LAT-1][1];
  assign LVBL_dly = blank_q[COLMIX_LAT-1][0];

  // Object bit 7 and the upper blue nibble are carried but never shown.
  assign w_unused = ^{obj_pxl[7], w_b_vid[7:4]};

endmodule
`default_nettype wire

// File: doc/jtdd_colmix.md
# jtdd_colmix

Colour mixer for the JTDD video path. It sits directly downstream of the character layer and merges that layer's 7-bit pixel with the object and scroll pixels. It resolves layer priority, looks the winner up in the CPU-writable palette RAM, and drives blank-gated 4-bit RGB with matching delayed blanking signals. The CPU reads and writes the palette through a dedicated dual-port RAM port, so the CPU never stalls video.

## Interface
Parameters:
- SIMFILE_RG, "pal_rg.bin", simulation preload for the red/green bank
- SIMFILE_B, "pal_b.bin", simulation preload for the blue bank

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- pxl_cen  in  1  pixel clock enable
- cen_E  in  1  CPU E-phase enable; qualifies palette writes
- cpu_AB  in  10  CPU address; [9] bank select (0 = RG, 1 = B), [8:0] palette index
- pal_cs  in  1  palette chip select
- cpu_wrn  in  1  CPU write, active low
- cpu_dout  in  8  CPU write data
- pal_dout  out  8  CPU read data
- char_pxl  in  7  character pixel {pal[2:0], col[3:0]}
- obj_pxl  in  8  object pixel; [3:0] colour, [6:4] palette, [7] unused
- scr_pxl  in  8  scroll pixel {pal[3:0], col[3:0]}
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- red  out  4  red output
- green  out  4  green output
- blue  out  4  blue output
- LHBL_dly  out  1  LHBL delayed to align with RGB
- LVBL_dly  out  1  LVBL delayed to align with RGB
- gfx_en  in  3  layer enables {scr, obj, char}; present only with JTDD_COLMIX_DEBUG_EN

## Operation
- **Priority.** Character over object over scroll.
  - The character pixel wins when char_pxl[3:0] != 0.
  - Otherwise the object pixel wins when obj_pxl[3:0] != 0.
  - Otherwise the scroll pixel wins. Scroll is never transparent; colour 0 is a valid colour.
- **Palette index (9 bits).**
  - Char: {2'b00, char_pxl}, range 0x000–0x07F.
  - Obj: {2'b01, obj_pxl[6:0]}, range 0x080–0x0FF.
  - Scroll: {1'b1, scr_pxl}, range 0x100–0x1FF.
- **Palette RAM.** Two 512x8 banks.
  - RG bank: [7:4] green, [3:0] red.
  - B bank: [3:0] blue; [7:4] is stored and reads back but is ignored for video.
- **CPU write.** Occurs on the clk where pal_cs && !cpu_wrn && cen_E. It writes cpu_dout into the bank selected by cpu_AB[9], at cpu_AB[8:0].
- **CPU read.** pal_dout presents the selected bank/index one clk after the address. A same-cycle write returns the old data.
- **Blanking.** When the delayed (LHBL & LVBL) is 0, RGB outputs are 0.
- **Reset.**
  - red, green, blue, LHBL_dly, LVBL_dly and the pipeline index registers all reset to 0.
  - RAM contents are not reset.
  - Asserting rst_n low mid-frame forces outputs to 0 immediately. The pipeline refills within 3 pxl_cen after release.

## Timing
- All video registers advance only on pxl_cen.
- **Stage 1:** the priority mux registers the 9-bit index and the blank bits.
- **Stage 2:** synchronous RAM read on the video port; blank bits are delayed.
- **Stage 3:** RGB is registered with blank gating; LHBL_dly and LVBL_dly are registered.
- **Latency.** A pixel presented on input cen N appears on RGB after cen N+3. LHBL_dly and LVBL_dly carry exactly the same delay.
- **CPU/video collision.** A CPU write to the entry being displayed takes effect on video at the next video-port read; there is no glitch within one pixel.
- **Simultaneous events.** pxl_cen and cen_E in the same clk are both honoured, with no priority between ports.

## Configuration
- **JTDD_COLMIX_DEBUG_EN defined:**
  - gfx_en exists.
  - A layer whose bit is 0 is treated as transparent: char and obj fall through.
  - Scroll disabled outputs palette index 0x100 forced to black (RGB 0).
- **Not defined:**
  - The port is absent.
  - All layers are always enabled.

## Structure
- jtdd_pkg holds:
  - CHAR_BASE = 2'b00 and OBJ_BASE = 2'b01, scroll selected by index [8] = 1.
  - PAL_AW = 9.
  - COLMIX_LAT = 3.
- Sub-module: jtframe_dual_ram, instantiated twice (RG and B banks).
  - Port A: CPU.
  - Port B: video.

## Test plan
- **Priority.** Write RG[0x012] = 0xA5, B[0x012] = 0x03. Drive char_pxl = 0x12, obj_pxl = 0x85, scr_pxl = 0x40, blanks high → after 3 pxl_cen, red = 5, green = A, blue = 3.
- **Fall-through.** char_pxl = 0x10 (transparent), obj_pxl = 0x05, scr_pxl = 0x77 → index 0x085; then obj_pxl = 0x00 → index 0x177. Check RGB against preloaded values.
- **Blanking.** Drop LHBL for 8 pixels with a nonzero pixel → RGB = 0 and LHBL_dly = 0 over exactly the 8 delayed pixels, both starting 3 pxl_cen late.
- **CPU readback.** Write 0xC3 to cpu_AB = 0x2FF → reading cpu_AB = 0x2FF returns 0xC3; cpu_AB = 0x0FF is unchanged.
- **Reset mid-frame.** Pulse rst_n low for 2 clk while active → outputs go 0 asynchronously; correct pixels resume 3 pxl_cen after release.
- **Debug build.** With JTDD_COLMIX_DEBUG_EN, gfx_en = 3'b110, char_pxl = 0x12 → the obj/scroll colour is shown instead of 0x012.
